// File: rtl/deadtime_pkg.sv
// deadtime_pkg: shared state encoding and constants for deadtime_gen.
// Optional fault state present only when DEADTIME_FAULT_EN is defined.
package deadtime_pkg;

  localparam int DT_WIDTH_DEF = 8;
  localparam int DT_MIN       = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAD_HS,
    S_HS_ON,
    S_DEAD_LS,
    S_LS_ON
`ifdef DEADTIME_FAULT_EN
    , S_FAULT
`endif
  } state_e;

endpackage

// File: rtl/deadtime_if.sv
// deadtime_if: leg command/status bundle (en, pwm_in, dead_cycles in;
// hs_out, ls_out, dead_active out; fault_* with DEADTIME_FAULT_EN).
interface deadtime_if
  import deadtime_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
);

  logic                en;
  logic                pwm_in;
  logic [DT_WIDTH-1:0] dead_cycles;
  logic                hs_out;
  logic                ls_out;
  logic                dead_active;
`ifdef DEADTIME_FAULT_EN
  logic                fault_in;
  logic                fault_clr;
  logic                fault_latched;

  modport master (
    output en, pwm_in, dead_cycles,
    output fault_in, fault_clr,
    input  hs_out, ls_out, dead_active,
    input  fault_latched
  );

  modport slave (
    input  en, pwm_in, dead_cycles,
    input  fault_in, fault_clr,
    output hs_out, ls_out, dead_active,
    output fault_latched
  );
`else
  modport master (
    output en, pwm_in, dead_cycles,
    input  hs_out, ls_out, dead_active
  );

  modport slave (
    input  en, pwm_in, dead_cycles,
    output hs_out, ls_out, dead_active
  );
`endif

endinterface

// File: rtl/deadtime_gen_dt_counter.sv
// dt_counter: loadable down-counter, saturates at 0.
// Ports: clk, rst, load, load_val -> done (count == DT_MIN).
module dt_counter
  import deadtime_pkg::*;
#(
  parameter int W = DT_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == W'(DT_MIN));

endmodule

// File: rtl/deadtime_gen.sv
// deadtime_gen: complementary HS/LS gate drive with dead time from pwm_in.
// Ports: clk, rst, bus (deadtime_if.slave); fault path with DEADTIME_FAULT_EN.
module deadtime_gen
  import deadtime_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic      clk,
  input  logic      rst,
  deadtime_if.slave bus
);

  state_e              state_q;
  state_e              state_d;
  logic                hs_q;
  logic                hs_d;
  logic                ls_q;
  logic                ls_d;
  logic                dead_q;
  logic                dead_d;
  logic                cnt_load;
  logic                cnt_done;
  logic [DT_WIDTH-1:0] load_val;

  // A zero dead time still yields a one-cycle gap.
  assign load_val = (bus.dead_cycles == '0)
                  ? DT_WIDTH'(DT_MIN)
                  : bus.dead_cycles;

  always_comb begin
    state_d = state_q;
`ifdef DEADTIME_FAULT_EN
    if (bus.fault_in) begin
      state_d = S_FAULT;
    end else if (state_q == S_FAULT) begin
      if (bus.fault_clr) begin
        state_d = S_IDLE;
      end
    end else
`endif
    if (!bus.en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = bus.pwm_in ? S_DEAD_HS : S_DEAD_LS;
        end
        // Reversal beats expiry so the full gap is always honoured.
        S_DEAD_HS: begin
          if (!bus.pwm_in) begin
            state_d = S_DEAD_LS;
          end else if (cnt_done) begin
            state_d = S_HS_ON;
          end
        end
        S_DEAD_LS: begin
          if (bus.pwm_in) begin
            state_d = S_DEAD_HS;
          end else if (cnt_done) begin
            state_d = S_LS_ON;
          end
        end
        S_HS_ON: begin
          if (!bus.pwm_in) begin
            state_d = S_DEAD_LS;
          end
        end
        S_LS_ON: begin
          if (bus.pwm_in) begin
            state_d = S_DEAD_HS;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    hs_d     = (state_d == S_HS_ON);
    ls_d     = (state_d == S_LS_ON);
    dead_d   = (state_d == S_DEAD_HS) || (state_d == S_DEAD_LS);
    // Reload on every dead-state entry, including a reversal.
    cnt_load = dead_d && (state_d != state_q);
  end

  dt_counter #(
    .W (DT_WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (load_val),
    .done     (cnt_done)
  );

`ifdef DEADTIME_FAULT_EN
  logic flt_q;
  logic flt_d;

  assign flt_d             = (state_d == S_FAULT);
  assign bus.fault_latched = flt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flt_q <= 1'b0;
    end else begin
      flt_q <= flt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_q    <= hs_d;
      ls_q    <= ls_d;
      dead_q  <= dead_d;
    end
  end

  assign bus.hs_out      = hs_q;
  assign bus.ls_out      = ls_q;
  assign bus.dead_active = dead_q;

endmodule
